// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Framed byte-stream loader that packs 9-bit instructions into IMEM
//            and holds the core in reset while loading or after an error.
// Option   : PROG_LOADER_OPCHECK_EN rejects undefined opcodes {14,15,23,26,27}
// Revision : 1.0  initial release
// ============================================================================
module prog_loader #(
    parameter int AW = 10,
    parameter int IW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [IW-1:0] imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic          cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_W_LO   = 3'd3,
        S_W_HI   = 3'd4,
        S_CSUM   = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [31:0] C_CAP = 32'd1 << AW;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [AW:0]   idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    lo_q, lo_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] wdata_q, wdata_d;
    logic [1:0]    code_q, code_d;

    logic          w_xfer;
    logic [15:0]   w_len;
    logic [AW:0]   w_idx_inc;
    logic [8:0]    w_word;
    logic          w_op_bad;

    assign in_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_W_LO)   || (state_q == S_W_HI)   ||
                       (state_q == S_CSUM);
    assign w_xfer    = in_valid & in_ready;
    assign w_len     = {in_data, len_q[7:0]};
    assign w_idx_inc = idx_q + {{AW{1'b0}}, 1'b1};
    assign w_word    = {in_data[0], lo_q};

`ifdef PROG_LOADER_OPCHECK_EN
    logic [4:0] w_op;
    assign w_op     = w_word[8:4];
    assign w_op_bad = (w_op == 5'd14) || (w_op == 5'd15) || (w_op == 5'd23) ||
                      (w_op == 5'd26) || (w_op == 5'd27);
`else
    assign w_op_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    code_d  = 2'b00;
                    sum_d   = 8'd0;
                    idx_d   = '0;
                end
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    len_d[7:0] = in_data;
                    sum_d      = sum_q + in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    len_d[15:8] = in_data;
                    sum_d       = sum_q + in_data;
                    if ({16'd0, w_len} > C_CAP) begin
                        state_d = S_ERR;
                        code_d  = 2'b01;
                    end else if (w_len == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_W_LO;
                    end
                end
            end
            S_W_LO: begin
                if (w_xfer) begin
                    lo_d    = in_data;
                    sum_d   = sum_q + in_data;
                    state_d = S_W_HI;
                end
            end
            S_W_HI: begin
                if (w_xfer) begin
                    sum_d = sum_q + in_data;
                    if ((in_data[7:1] != 7'd0) || w_op_bad) begin
                        state_d = S_ERR;
                        code_d  = 2'b10;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = idx_q[AW-1:0];
                        wdata_d = w_word;
                        idx_d   = w_idx_inc;
                        // Index is AW+1 bits so N == 2^AW terminates without wrapping.
                        state_d = (32'(w_idx_inc) == {16'd0, len_q}) ? S_CSUM : S_W_LO;
                    end
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    if (in_data == sum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        code_d  = 2'b11;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            code_q  <= code_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = in_ready;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign err_code   = code_q;
    assign cpu_hold   = busy | error;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Directed self-checking bench for prog_loader (AW=10).
// Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

    localparam int AW = 10;
    localparam int IW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic          cpu_hold;

    int n_cmp = 0;
    int n_err = 0;
    int wr_total = 0;
    int base;
    logic [AW-1:0] log_addr [0:4095];
    logic [IW-1:0] log_data [0:4095];
    logic [7:0]    csum;

    prog_loader #(.AW(AW), .IW(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            log_addr[wr_total] = imem_addr;
            log_data[wr_total] = imem_wdata;
            wr_total = wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_two(input logic [7:0] cs);
        send(8'h02); send(8'h00);
        send(8'h40); send(8'h01);
        send(8'h1F); send(8'h00);
        send(cs);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clk); @(negedge clk);
        // {in_ready,imem_we,busy,done,error,cpu_hold,err_code,addr,wdata}
        chk("reset_outputs", {in_ready, imem_we, busy, done, error, cpu_hold, err_code,
                              imem_addr, imem_wdata}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Two-word frame, good checksum 0x62
        base = wr_total;
        pulse_start();
        chk("busy_after_start", {busy, cpu_hold, done, error}, 32'b1100);
        load_two(8'h62);
        chk("t1_status", {done, error, busy, cpu_hold, err_code}, 32'b100000);
        chk("t1_wr_count", wr_total - base, 32'd2);
        chk("t1_w0", {log_addr[base], log_data[base]}, {10'd0, 9'h140});
        chk("t1_w1", {log_addr[base+1], log_data[base+1]}, {10'd1, 9'h01F});

        // Empty frame
        base = wr_total;
        pulse_start();
        chk("t2_done_cleared", done, 1'b0);
        send(8'h00); send(8'h00); send(8'h00);
        chk("t2_status", {done, error, cpu_hold, err_code}, 32'b10000);
        chk("t2_wr_count", wr_total - base, 32'd0);

        // Bad HI byte format
        base = wr_total;
        pulse_start();
        send(8'h01); send(8'h00); send(8'h40); send(8'h03);
        chk("t3_status", {done, error, in_ready, cpu_hold, err_code}, 32'b010110);
        chk("t3_wr_count", wr_total - base, 32'd0);

        // Opcode 14 word 0x0E0, checksum 01+00+E0+00 = E1
        base = wr_total;
        pulse_start();
        chk("t4_err_cleared", {error, err_code}, 32'd0);
        send(8'h01); send(8'h00); send(8'hE0); send(8'h00);
`ifdef PROG_LOADER_OPCHECK_EN
        chk("t4_status", {done, error, err_code}, 32'b0110);
        chk("t4_wr_count", wr_total - base, 32'd0);
`else
        send(8'hE1);
        chk("t4_status", {done, error, err_code}, 32'b1000);
        chk("t4_wr_count", wr_total - base, 32'd1);
        chk("t4_w0", {log_addr[base], log_data[base]}, {10'd0, 9'h0E0});
`endif

        // Checksum off by one
        base = wr_total;
        pulse_start();
        load_two(8'h63);
        chk("t5_status", {done, error, cpu_hold, err_code}, 32'b01111);
        chk("t5_wr_count", wr_total - base, 32'd2);

        // Length one past capacity
        base = wr_total;
        pulse_start();
        send(8'h01); send(8'h04);
        chk("t6_status", {done, error, in_ready, err_code}, 32'b01001);
        chk("t6_wr_count", wr_total - base, 32'd0);

        // Exactly full memory: 1024 words, opcode 1, reg = i[3:0]
        base = wr_total;
        pulse_start();
        csum = 8'h04;
        send(8'h00); send(8'h04);
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] lo;
            lo = 8'h10 | 8'(i[3:0]);
            csum = csum + lo;
            send(lo); send(8'h00);
        end
        send(csum);
        chk("t7_status", {done, error, err_code}, 32'b1000);
        chk("t7_wr_count", wr_total - base, 32'd1024);
        chk("t7_last", {log_addr[base+1023], log_data[base+1023]}, {10'h3FF, 9'h01F});
        chk("t7_mid", {log_addr[base+517], log_data[base+517]}, {10'd517, 9'h015});

        // Reset with a write in flight
        pulse_start();
        send(8'h01); send(8'h00); send(8'h40);
        base = wr_total;
        in_valid = 1'b1; in_data = 8'h01;
        @(posedge clk); #1;
        chk("t8_we_in_flight", imem_we, 1'b1);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t8_reset_outputs", {in_ready, imem_we, busy, done, error, cpu_hold, err_code,
                                 imem_addr, imem_wdata}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t8_write_dropped", wr_total - base, 32'd0);
        pulse_start();
        load_two(8'h62);
        chk("t8_reload_status", {done, error, err_code}, 32'b1000);
        chk("t8_reload_count", wr_total - base, 32'd2);
        chk("t8_reload_w1", {log_addr[base+1], log_data[base+1]}, {10'd1, 9'h01F});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
